// File: rtl/cam_capture_rgb444_if.sv
// Frame-buffer write port: one address/data word qualified by a one-cycle regwrite strobe.
// There is no back-pressure; the buffer accepts every cycle in which regwrite is high.
interface cam_capture_rgb444_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite;

  modport master (output addr_in, output data_in, output regwrite);
  modport slave  (input  addr_in, input  data_in, input  regwrite);
endinterface

// File: rtl/cam_capture_rgb444.sv
// OV7670 RGB444 capture: packs byte pairs into 12-bit pixels and writes one 160x120 frame.
// Build option CAP_TESTPAT_EN replaces camera data with colour bars selected by column.
module cam_capture_rgb444 #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cap_en,
  input  logic                 vsync,
  input  logic                 href,
  input  logic [7:0]           px_data,
  cam_capture_rgb444_if.master wr,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 ovf,
  output logic [1:0]           dbg_state_o
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    CAPTURE    = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic          vsync_q, href_q;
  logic          phase_q;
  logic [3:0]    red_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [AW-1:0] row_base_q;
  logic          line_wr_q;
  logic          ovf_q;
  logic          frame_done_q;
  logic          regwrite_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  logic          vs_rise, vs_fall, start_frame, in_bounds;
  logic [DW-1:0] pix_d;

  assign vs_rise     = ~vsync_q & vsync;
  assign vs_fall     = vsync_q & ~vsync;
  assign start_frame = (state_q == WAIT_START) && vs_fall;
  assign in_bounds   = (col_q < COL_MAX) && (row_q < ROW_MAX);

`ifdef CAP_TESTPAT_EN
  logic [7:0] col8;
  assign col8 = 8'(col_q);

  always_comb begin
    pix_d = '0;
    case (col8[7:5])
      3'd0:    pix_d = DW'(12'hFFF);
      3'd1:    pix_d = DW'(12'hFF0);
      3'd2:    pix_d = DW'(12'h0FF);
      3'd3:    pix_d = DW'(12'h0F0);
      3'd4:    pix_d = DW'(12'hF0F);
      3'd5:    pix_d = DW'(12'hF00);
      3'd6:    pix_d = DW'(12'h00F);
      default: pix_d = DW'(12'h000);
    endcase
  end
`else
  assign pix_d = DW'({red_q, px_data});
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (cap_en)  state_d = WAIT_START;
      WAIT_START: if (vs_fall) state_d = CAPTURE;
      CAPTURE:    if (vs_rise) state_d = cap_en ? WAIT_START : IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state_q == WAIT_START) || (state_q == CAPTURE);
    dbg_state_o = state_q;
  end

  // Datapath: byte packing, running address, bounds and frame flags.
  // The address is the row base (stepped by IMG_W) plus column, so no multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      phase_q      <= 1'b0;
      red_q        <= '0;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      line_wr_q    <= 1'b0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
      regwrite_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      vsync_q      <= vsync;
      href_q       <= href;
      regwrite_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (start_frame) begin
        phase_q    <= 1'b0;
        col_q      <= '0;
        row_q      <= '0;
        row_base_q <= '0;
        line_wr_q  <= 1'b0;
        ovf_q      <= 1'b0;
        addr_q     <= '0;
      end else if (state_q == CAPTURE) begin
        if (vs_rise) frame_done_q <= 1'b1;
        if (href) begin
          phase_q <= ~phase_q;
          if (!phase_q) begin
            red_q <= px_data[3:0];
          end else begin
            if (in_bounds) begin
              regwrite_q <= 1'b1;
              addr_q     <= row_base_q + AW'(col_q);
              data_q     <= pix_d;
              line_wr_q  <= 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
            if (col_q != COL_MAX) col_q <= col_q + 1'b1;
          end
        end else if (href_q) begin
          // Line end: an odd trailing byte is dropped with the phase reset.
          phase_q   <= 1'b0;
          col_q     <= '0;
          line_wr_q <= 1'b0;
          if (line_wr_q && (row_q != ROW_MAX)) begin
            row_q      <= row_q + 1'b1;
            row_base_q <= row_base_q + AW'(IMG_W);
          end
        end
      end
    end
  end

  assign wr.addr_in  = addr_q;
  assign wr.data_in  = data_q;
  assign wr.regwrite = regwrite_q;
  assign frame_done  = frame_done_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Scoreboard bench for cam_capture_rgb444: expected {addr,data} queued as bytes are driven,
// popped and compared whenever regwrite is seen.
module tb_cam_capture_rgb444;

  localparam int AW    = 15;
  localparam int DW    = 12;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cap_en = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] px_data = '0;
  logic       frame_done, busy, ovf;
  logic [1:0] dbg_state;

  cam_capture_rgb444_if #(.AW(AW), .DW(DW)) wr_if ();

  cam_capture_rgb444 #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .reset      (reset),
    .cap_en     (cap_en),
    .vsync      (vsync),
    .href       (href),
    .px_data    (px_data),
    .wr         (wr_if),
    .frame_done (frame_done),
    .busy       (busy),
    .ovf        (ovf),
    .dbg_state_o(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;
  int exp_fd   = 0;
  int m_row    = 0;
  int last_addr = -1;
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_pix(input int col, input logic [3:0] r, input logic [7:0] b);
    logic [11:0] bars [8];
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
`ifdef CAP_TESTPAT_EN
    return bars[(col >> 5) & 7];
`else
    if (col < 0) return bars[0];
    return {r, b};
`endif
  endfunction

  // Scoreboard monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (frame_done) fd_cnt++;
    if (wr_if.regwrite) begin
      check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
      check("addr_range", 32'(wr_if.addr_in < AW'(IMG_W * IMG_H)), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(wr_if.addr_in), 32'(e[AW+DW-1:DW]));
        check("wr_data", 32'(wr_if.data_in), 32'(e[DW-1:0]));
      end
      last_addr = int'(wr_if.addr_in);
    end
  end

  // Driver tasks
  task automatic start_frame();
    @(negedge clk); vsync = 1'b1; href = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b0; m_row = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk); vsync = 1'b1; href = 1'b0; exp_fd++;
    repeat (4) @(negedge clk);
    check("frame_done_cnt", 32'(fd_cnt), 32'(exp_fd));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Drives nbytes on one line and queues the pixels the model says get stored.
  task automatic send_line(input int nbytes, input bit end_line);
    logic [7:0] b;
    logic [3:0] r;
    int px;
    bit wrote;
    px = 0; wrote = 0; r = '0;
    for (int i = 0; i < nbytes; i++) begin
      b = 8'($urandom_range(0, 255));
      @(negedge clk); href = 1'b1; px_data = b;
      if (i % 2 == 0) r = b[3:0];
      else begin
        if (px < IMG_W && m_row < IMG_H) begin
          exp_q.push_back({AW'(m_row * IMG_W + px), exp_pix(px, r, b)});
          wrote = 1;
        end
        px++;
      end
    end
    if (end_line) begin
      @(negedge clk); href = 1'b0; px_data = '0;
      repeat (GAP) @(negedge clk);
      if (wrote) m_row++;
    end
  endtask

  initial begin
    logic [7:0] b0, b1;

    // Reset state
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_addr", 32'(wr_if.addr_in), 0);
    check("rst_data", 32'(wr_if.data_in), 0);
    check("rst_regwrite", 32'(wr_if.regwrite), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_state", 32'(dbg_state), 0);

    cap_en = 1'b1;
    repeat (2) @(negedge clk);
    check("wait_busy", 32'(busy), 1);

    // 0A,BC packs to ABC at address 0, one clock after the second byte
    start_frame();
    @(negedge clk); href = 1'b1; px_data = 8'h0A;
    @(negedge clk); px_data = 8'hBC;
    exp_q.push_back({AW'(0), exp_pix(0, 4'hA, 8'hBC)});
    check("t2_no_wr_early", 32'(wr_if.regwrite), 0);
    @(negedge clk); href = 1'b0; px_data = '0;
    check("t2_regwrite", 32'(wr_if.regwrite), 1);
    check("t2_data", 32'(wr_if.data_in), 32'(exp_pix(0, 4'hA, 8'hBC)));
    check("t2_addr", 32'(wr_if.addr_in), 0);
    repeat (GAP) @(negedge clk);
    end_frame();

    // Full frame: 120 lines of 320 bytes
    start_frame();
    for (int l = 0; l < IMG_H; l++) send_line(2 * IMG_W, 1'b1);
    check("t1_last_addr", 32'(last_addr), 32'(IMG_W * IMG_H - 1));
    check("t1_ovf", 32'(ovf), 0);
    end_frame();

    // Odd line, overlong line, then a 121st line
    start_frame();
    send_line(2 * IMG_W + 1, 1'b1);
    send_line(2, 1'b1);
    check("t3_addr160", 32'(last_addr), 32'(IMG_W));
    check("t3_no_ovf", 32'(ovf), 0);
    send_line(340, 1'b1);
    check("t4_ovf", 32'(ovf), 1);
    for (int l = 3; l < IMG_H; l++) send_line(2, 1'b1);
    send_line(20, 1'b1);
    check("t4_last_addr", 32'(last_addr), 32'((IMG_H - 1) * IMG_W));
    end_frame();
    check("ovf_sticky", 32'(ovf), 1);
    start_frame();
    check("ovf_clear", 32'(ovf), 0);

    // Reset pulsed mid-line
    send_line(10, 1'b0);
    @(negedge clk); reset = 1'b1; px_data = 8'($urandom_range(0, 255));
    @(negedge clk);
    check("t5_addr", 32'(wr_if.addr_in), 0);
    check("t5_data", 32'(wr_if.data_in), 0);
    check("t5_regwrite", 32'(wr_if.regwrite), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_state", 32'(dbg_state), 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); href = 1'(i % 4 != 3); px_data = 8'($urandom_range(0, 255));
    end
    @(negedge clk); href = 1'b0;
    check("t5_waiting", 32'(busy), 1);
    check("t5_queue", 32'(exp_q.size()), 0);
    start_frame();
    send_line(4, 1'b1);
    check("t5_resume_addr", 32'(last_addr), 1);
    end_frame();

    // vsync rise coincides with the second byte of a pixel
    start_frame();
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    @(negedge clk); href = 1'b1; px_data = b0;
    @(negedge clk); px_data = b1; vsync = 1'b1; cap_en = 1'b0;
    exp_q.push_back({AW'(0), exp_pix(0, b0[3:0], b1)});
    exp_fd++;
    @(negedge clk); href = 1'b0; px_data = '0;
    check("sim_regwrite", 32'(wr_if.regwrite), 1);
    check("sim_frame_done", 32'(frame_done), 1);
    repeat (3) @(negedge clk);
    check("sim_idle", 32'(busy), 0);
    check("sim_fd_cnt", 32'(fd_cnt), 32'(exp_fd));
    check("sim_queue", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
